// File: rtl/qtr_pkg.sv
// Shared types and timing helpers for the QTR reflectance sensor front end.
package qtr_pkg;

  localparam int VALUE_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHARGE    = 2'd1,
    DISCHARGE = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Whole clock cycles in a given number of microseconds.
  function automatic int cycles_for_us(input int clk_hz, input int us);
    return clk_hz / 1_000_000 * us;
  endfunction

  function automatic int charge_cycles(input int clk_hz, input int charge_us);
    return cycles_for_us(clk_hz, charge_us);
  endfunction

  function automatic int tick_cycles(input int clk_hz, input int tick_us);
    return cycles_for_us(clk_hz, tick_us);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous sensor pad input.
// Resets high so a discharged pad only reads low once it has really been sampled.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops
  // sample their inputs from the same edge and the chain cannot collapse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qtr_discharge_timer.sv
// QTR-RC sensor driver: charge the node, release it, and count discharge time
// in ticks; presents the result with a one-cycle valid strobe.
module qtr_discharge_timer
  import qtr_pkg::*;
#(
  parameter int CLK_FREQUENCY = 60_000_000,
  parameter int CHARGE_US     = 10,
  parameter int TICK_US       = 10,
  parameter int VALUE_WIDTH   = VALUE_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  output logic [VALUE_WIDTH-1:0] value,
  output logic                   valid,
  output logic                   busy,
  output logic                   qtr_out_en,
  output logic                   qtr_out_sig,
  input  logic                   qtr_in_sig,
  output logic                   qtr_ctrl
);

  localparam int CHARGE_CYC = charge_cycles(CLK_FREQUENCY, CHARGE_US);
  localparam int TICK_CYC   = tick_cycles(CLK_FREQUENCY, TICK_US);
  localparam int MAX_CYC    = (CHARGE_CYC > TICK_CYC) ? CHARGE_CYC : TICK_CYC;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]       CHARGE_LAST = CNT_W'(CHARGE_CYC - 1);
  localparam logic [CNT_W-1:0]       TICK_LAST   = CNT_W'(TICK_CYC - 1);
  localparam logic [VALUE_WIDTH-1:0] TICK_MAX    = '1;

  if (CHARGE_CYC < 2 || TICK_CYC < 2) begin : g_bad_timing
    $error("qtr_discharge_timer: charge and tick periods must be at least 2 cycles");
  end

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cyc_cnt, cyc_next;
  logic [VALUE_WIDTH-1:0] tick_cnt, tick_next;
  logic                   in_s;
  logic                   tick_wrap;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (qtr_in_sig),
    .q       (in_s)
  );

  assign tick_wrap = (cyc_cnt == TICK_LAST);

  // NOTE: every variable driven here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cyc_next   = cyc_cnt + 1'b1;
    tick_next  = tick_cnt;
    unique case (state)
      IDLE: begin
        cyc_next = '0;
        if (en) begin
          state_next = CHARGE;
          tick_next  = '0;
        end
      end
      CHARGE: begin
        if (cyc_cnt == CHARGE_LAST) begin
          state_next = DISCHARGE;
          cyc_next   = '0;
        end
      end
      DISCHARGE: begin
        if (tick_wrap) begin
          cyc_next = '0;
          if (tick_cnt != TICK_MAX) tick_next = tick_cnt + 1'b1;
        end
        // A low pad wins over a coincident wrap; the result is the count
        // before that wrap. Saturated count plus another wrap is a timeout.
        if (!in_s || (tick_wrap && tick_cnt == TICK_MAX)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        cyc_next   = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      tick_cnt    <= '0;
      value       <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      qtr_out_en  <= 1'b0;
      qtr_out_sig <= 1'b0;
      qtr_ctrl    <= 1'b0;
    end else begin
      state       <= state_next;
      cyc_cnt     <= cyc_next;
      tick_cnt    <= tick_next;
      valid       <= (state_next == DONE);
      busy        <= (state_next != IDLE);
      qtr_out_en  <= (state_next == CHARGE);
      qtr_out_sig <= (state_next == CHARGE);
      qtr_ctrl    <= (state_next != IDLE);
      if (state_next == DONE) value <= tick_cnt;
    end
  end

endmodule

// File: tb/tb_qtr_discharge_timer.sv
// Scoreboard bench for qtr_discharge_timer at 1 MHz: CHARGE_CYC = TICK_CYC = 10.
module tb_qtr_discharge_timer;

  localparam int CHARGE_CYC = 10;
  localparam int TICK_CYC   = 10;
  localparam int BUDGET     = 4000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [7:0] value;
  logic       valid;
  logic       busy;
  logic       qtr_out_en;
  logic       qtr_out_sig;
  logic       qtr_in_sig;
  logic       qtr_ctrl;

  qtr_discharge_timer #(
    .CLK_FREQUENCY (1_000_000),
    .CHARGE_US     (10),
    .TICK_US       (10),
    .VALUE_WIDTH   (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .value       (value),
    .valid       (valid),
    .busy        (busy),
    .qtr_out_en  (qtr_out_en),
    .qtr_out_sig (qtr_out_sig),
    .qtr_in_sig  (qtr_in_sig),
    .qtr_ctrl    (qtr_ctrl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int exp_q[$];

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pad model: the sensor node follows the driver while driven; once released
  // it reads high until discharge_cyc cycles after DISCHARGE entry.
  // discharge_cyc: 0 = node always low, <0 = never discharges.
  int   discharge_cyc = -1;
  logic pad_level     = 1'b1;
  bit   in_dis        = 0;
  int   dis_idx       = 0;
  logic out_en_prev   = 1'b0;

  assign qtr_in_sig = qtr_out_en ? qtr_out_sig : pad_level;

  always @(posedge clk) begin
    #2;
    if (!busy) in_dis = 0;
    else if (out_en_prev && !qtr_out_en) begin
      in_dis  = 1;
      dis_idx = 0;
    end else if (in_dis) dis_idx++;
    out_en_prev = qtr_out_en;
    if (discharge_cyc == 0) pad_level = 1'b0;
    else if (discharge_cyc > 0 && in_dis && dis_idx >= discharge_cyc) pad_level = 1'b0;
    else pad_level = 1'b1;
  end

  // Monitor: every valid must match the oldest expected value, and busy must
  // be low on the following cycle.
  bit busy_pending = 0;
  always @(negedge clk) begin
    if (busy_pending) begin
      check(!busy, "busy_after_valid", int'(busy), 0);
      busy_pending = 0;
    end
    if (reset_n && valid) begin
      n_valid++;
      busy_pending = 1;
      check(exp_q.size() != 0, "valid_expected", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        check(int'(value) == e, "value", int'(value), e);
      end
    end
  end

  // One measurement: pulse en, optionally poke en in CHARGE and DISCHARGE,
  // and report charge length, DISCHARGE-entry-to-valid latency and whether
  // qtr_ctrl stayed high while busy. Returns in the IDLE cycle after valid.
  task automatic measure(input int dcyc, input int exp_v, input bit poke,
                         output int chg_cycles, output int dis_lat, output bit ctrl_ok);
    int dis_start;
    bit got;
    dis_start     = -1;
    got           = 0;
    chg_cycles    = 0;
    dis_lat       = -1;
    ctrl_ok       = 1;
    discharge_cyc = dcyc;
    exp_q.push_back(exp_v);
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      if (qtr_out_en) chg_cycles++;
      if (!qtr_out_en && dis_start < 0 && chg_cycles > 0) dis_start = i;
      if (busy && !qtr_ctrl) ctrl_ok = 0;
      if (valid) begin
        got     = 1;
        dis_lat = i - dis_start;
      end else begin
        en = poke && (i == 3 || i == 20);
        step();
        en = 1'b0;
      end
    end
    check(got, "valid_within_budget", int'(got), 1);
    step();
  endtask

  int  chg, lat, v0, busy_cnt;
  bit  ctrl_ok;

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    #1;
    check({qtr_out_en, qtr_out_sig, qtr_ctrl, busy, valid} == 5'b0, "reset_ctl",
          int'({qtr_out_en, qtr_out_sig, qtr_ctrl, busy, valid}), 0);
    check(value == 8'd0, "reset_value", int'(value), 0);
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Nominal: pad low 55 cycles into DISCHARGE -> 5 ticks.
    measure(55, 5, 0, chg, lat, ctrl_ok);
    check(chg == CHARGE_CYC, "nominal_charge_len", chg, CHARGE_CYC);
    check(lat >= 57 && lat <= 58, "nominal_latency", lat, 58);

    // Timeout: 256 wraps of TICK_CYC (2570 cycles from CHARGE start).
    measure(-1, 255, 0, chg, lat, ctrl_ok);
    check(lat >= 256 * TICK_CYC - 3 && lat <= 256 * TICK_CYC + 3, "timeout_latency",
          lat, 256 * TICK_CYC);
    check(ctrl_ok, "timeout_ctrl_busy", int'(ctrl_ok), 1);
    check(!qtr_ctrl && !busy, "idle_ctrl_low", int'({qtr_ctrl, busy}), 0);

    // Node already low when released.
    repeat (5) step();
    measure(0, 0, 0, chg, lat, ctrl_ok);
    check(lat >= 1 && lat <= 3, "immediate_latency", lat, 3);

    // en while busy is dropped.
    v0 = n_valid;
    measure(30, 3, 1, chg, lat, ctrl_ok);
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy) busy_cnt++;
      step();
    end
    check(busy_cnt == 0, "no_queued_start", busy_cnt, 0);
    check(n_valid - v0 == 1, "single_valid_when_poked", n_valid - v0, 1);

    // Reset asserted mid-DISCHARGE around tick 3.
    discharge_cyc = -1;
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (CHARGE_CYC + 35) step();
    check(busy && !qtr_out_en, "in_discharge_before_reset", int'({busy, qtr_out_en}), 2);
    #2 reset_n = 1'b0;
    #1;
    check({qtr_out_en, qtr_ctrl, busy, valid} == 4'b0, "async_reset_ctl",
          int'({qtr_out_en, qtr_ctrl, busy, valid}), 0);
    check(value == 8'd0, "async_reset_value", int'(value), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    v0 = n_valid;
    repeat (50) step();
    check(n_valid == v0, "no_valid_after_abort", n_valid - v0, 0);
    measure(40, 4, 0, chg, lat, ctrl_ok);
    check(chg == CHARGE_CYC, "post_reset_charge_len", chg, CHARGE_CYC);

    // Back-to-back: en in the cycle after each valid.
    measure(20, 2, 0, chg, lat, ctrl_ok);
    measure(80, 8, 0, chg, lat, ctrl_ok);
    check(chg == CHARGE_CYC, "back_to_back_charge_len", chg, CHARGE_CYC);

    repeat (5) step();
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
